// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream point-to-point link: valid/ready handshake with a data payload.
// The manager (m) drives tvalid/tdata; the subordinate (s) drives tready.
interface axis_if #(
  parameter int TDATA_WIDTH = 8
) ();
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin merge of NUM_REQ AXI-Stream inputs into one registered output,
// with a bounded burst lock of up to MAX_BURST beats per grant tenure.
module axis_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_if.s                          axis_sif [NUM_REQ],
  axis_if.m                          axis_mif,
  output logic [$clog2(NUM_REQ)-1:0] mif_id,
  input  logic                       invalidate
);
  localparam int ID_WIDTH    = $clog2(NUM_REQ);
  localparam int IDX_WIDTH   = ID_WIDTH + 1;
  localparam int CNT_WIDTH   = $clog2(MAX_BURST) + 1;
  localparam int TDATA_WIDTH = $bits(axis_mif.tdata);

  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} state_e;

  if (NUM_REQ < 2) begin : g_bad_num_req
    $fatal(1, "axis_rr_arbiter: NUM_REQ must be >= 2");
  end
  if (MAX_BURST < 1) begin : g_bad_max_burst
    $fatal(1, "axis_rr_arbiter: MAX_BURST must be >= 1");
  end

  logic [NUM_REQ-1:0]     vld_s;
  logic [NUM_REQ-1:0]     rdy_s;
  logic [TDATA_WIDTH-1:0] data_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sif
    if ($bits(axis_sif[g].tdata) != TDATA_WIDTH) begin : g_width_mismatch
      $fatal(1, "axis_rr_arbiter: input tdata width differs from output");
    end
    assign vld_s[g]           = axis_sif[g].tvalid;
    assign data_s[g]          = axis_sif[g].tdata;
    assign axis_sif[g].tready = rdy_s[g];
  end

  state_e                 state_q,  state_d;
  logic [ID_WIDTH-1:0]    owner_q,  owner_d;
  logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]   cnt_q,    cnt_d;
  logic                   tvalid_q, tvalid_d;
  logic [TDATA_WIDTH-1:0] tdata_q,  tdata_d;
  logic [ID_WIDTH-1:0]    id_q,     id_d;

  logic                   any_valid_s;
  logic                   load_en_s;
  logic                   hs_s;
  logic                   found_s;
  logic [ID_WIDTH-1:0]    sel_s;
  logic [IDX_WIDTH-1:0]   scan_idx_s;
  logic [ID_WIDTH-1:0]    sel_inc_s;
  logic [ID_WIDTH-1:0]    owner_inc_s;
  logic [CNT_WIDTH-1:0]   n_s;

  assign any_valid_s = |vld_s;
  assign load_en_s   = !tvalid_q || axis_mif.tready;
  assign hs_s        = load_en_s && !invalidate && !rst && any_valid_s;

  // Grant selection: a valid owner keeps the grant, otherwise scan from rr_ptr.
  always_comb begin
    sel_s      = rr_ptr_q;
    found_s    = 1'b0;
    scan_idx_s = '0;
    if ((state_q == HOLD) && vld_s[owner_q]) begin
      sel_s   = owner_q;
      found_s = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        // Explicit subtract keeps the wrap exact for non-power-of-2 NUM_REQ.
        scan_idx_s = {1'b0, rr_ptr_q} + IDX_WIDTH'(k);
        if (scan_idx_s >= IDX_WIDTH'(NUM_REQ)) begin
          scan_idx_s = scan_idx_s - IDX_WIDTH'(NUM_REQ);
        end else begin
          scan_idx_s = scan_idx_s;
        end
        if (!found_s && vld_s[scan_idx_s[ID_WIDTH-1:0]]) begin
          sel_s   = scan_idx_s[ID_WIDTH-1:0];
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  assign sel_inc_s   = (sel_s == ID_WIDTH'(NUM_REQ - 1))   ? '0 : sel_s + ID_WIDTH'(1);
  assign owner_inc_s = (owner_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : owner_q + ID_WIDTH'(1);
  assign n_s         = ((state_q == HOLD) && (sel_s == owner_q)) ? cnt_q + CNT_WIDTH'(1)
                                                                  : CNT_WIDTH'(1);

  // Next-state and output-register computation.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    id_d     = id_q;
    if (invalidate) begin
      tvalid_d = 1'b0;
      state_d  = ARB;
      cnt_d    = '0;
    end else if (load_en_s) begin
      if (hs_s) begin
        tvalid_d = 1'b1;
        tdata_d  = data_s[sel_s];
        id_d     = sel_s;
        if (n_s == CNT_WIDTH'(MAX_BURST)) begin
          state_d  = ARB;
          rr_ptr_d = sel_inc_s;
          cnt_d    = '0;
        end else begin
          state_d  = HOLD;
          owner_d  = sel_s;
          cnt_d    = n_s;
        end
      end else begin
        tvalid_d = 1'b0;
        if (state_q == HOLD) begin
          state_d  = ARB;
          rr_ptr_d = owner_inc_s;
          cnt_d    = '0;
        end else begin
          state_d  = state_q;
        end
      end
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  // Input ready: only the selected requester, only when a beat is taken.
  always_comb begin
    rdy_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs_s && (sel_s == ID_WIDTH'(i))) begin
        rdy_s[i] = 1'b1;
      end else begin
        rdy_s[i] = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      id_q     <= id_d;
    end
  end

  assign axis_mif.tvalid = tvalid_q;
  assign axis_mif.tdata  = tdata_q;
  assign mif_id          = id_q;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: a 4x4 instance checked against a scoreboard model,
// and a 3-input pure round-robin instance checked against a fixed id sequence.
module tb_axis_rr_arbiter;
  localparam int NA  = 4;
  localparam int MBA = 4;
  localparam int NB  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A: 4 requesters, burst 4 ----------------
  logic [NA-1:0] vld_a = '0;
  logic [NA-1:0] rdy_a;
  logic [15:0]   dat_a [NA];
  logic          mtr_a = 1'b1;
  logic          inv_a = 1'b0;
  logic [1:0]    id_a;

  axis_if #(.TDATA_WIDTH(16)) sif_a [NA] ();
  axis_if #(.TDATA_WIDTH(16)) mif_a ();

  for (genvar g = 0; g < NA; g++) begin : g_a
    assign sif_a[g].tvalid = vld_a[g];
    assign sif_a[g].tdata  = dat_a[g];
    assign rdy_a[g]        = sif_a[g].tready;
  end
  assign mif_a.tready = mtr_a;

  axis_rr_arbiter #(.NUM_REQ(NA), .MAX_BURST(MBA)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .axis_sif   (sif_a),
    .axis_mif   (mif_a),
    .mif_id     (id_a),
    .invalidate (inv_a)
  );

  typedef struct {
    int          id;
    logic [15:0] data;
  } beat_t;

  beat_t sb[$];
  int    log_ids[$];
  int    m_state = 0;
  int    m_owner = 0;
  int    m_ptr   = 0;
  int    m_cnt   = 0;
  bit    m_tv    = 1'b0;
  int    hs_sel  = -1;
  int    src_cnt [NA];
  bit    stream  = 1'b0;

  // Reference behaviour for one clock: checks the cycle's DUT outputs, then advances.
  task automatic model_eval();
    int   sel;
    int   j;
    int   n;
    bit   load;
    bit   hs;
    logic [NA-1:0] er;
    if (rst) begin
      chk_eq("rst_tready", 32'(rdy_a), 32'd0);
      chk_eq("rst_tvalid", 32'(mif_a.tvalid), 32'd0);
      m_state = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_tv = 1'b0;
      hs_sel  = -1;
      sb.delete();
    end else begin
      load = !m_tv || mtr_a;
      sel  = -1;
      if (m_state == 1 && vld_a[m_owner]) begin
        sel = m_owner;
      end else begin
        for (int k = 0; k < NA; k++) begin
          j = (m_ptr + k) % NA;
          if (sel < 0 && vld_a[j]) sel = j;
        end
      end
      hs = load && !inv_a && (sel >= 0);
      er = hs ? NA'(1 << sel) : '0;
      chk_eq("tready", 32'(rdy_a), 32'(er));
      chk_eq("out_tvalid", 32'(mif_a.tvalid), 32'(m_tv));
      if (m_tv) begin
        chk_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          chk_eq("out_id", 32'(id_a), 32'(sb[0].id));
          chk_eq("out_data", 32'(mif_a.tdata), 32'(sb[0].data));
          if (mtr_a) begin
            log_ids.push_back(sb[0].id);
            void'(sb.pop_front());
          end else if (inv_a) begin
            void'(sb.pop_front());
          end
        end
      end
      hs_sel = hs ? sel : -1;
      if (inv_a) begin
        m_tv = 1'b0; m_state = 0; m_cnt = 0;
      end else if (load) begin
        if (hs) begin
          m_tv = 1'b1;
          sb.push_back('{id: sel, data: dat_a[sel]});
          n = (m_state == 1 && sel == m_owner) ? m_cnt + 1 : 1;
          if (n == MBA) begin
            m_state = 0; m_ptr = (sel + 1) % NA; m_cnt = 0;
          end else begin
            m_state = 1; m_owner = sel; m_cnt = n;
          end
        end else begin
          m_tv = 1'b0;
          if (m_state == 1) begin
            m_state = 0; m_ptr = (m_owner + 1) % NA; m_cnt = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input logic [NA-1:0] vld, input logic mtr, input logic inv, input logic r);
    @(posedge clk);
    #1;
    if (hs_sel >= 0) src_cnt[hs_sel]++;
    rst   = r;
    vld_a = vld;
    mtr_a = mtr;
    inv_a = inv;
    if (stream) begin
      for (int i = 0; i < NA; i++) dat_a[i] = 16'(i * 4096 + src_cnt[i]);
    end
    @(negedge clk);
    model_eval();
  endtask

  // ---------------- instance B: 3 requesters, pure round-robin ----------------
  logic [NB-1:0] vld_b = '0;
  logic [NB-1:0] rdy_b;
  logic [7:0]    dat_b [NB];
  logic [1:0]    id_b;
  bit            b_done = 1'b0;
  int            qb[$];

  axis_if #(.TDATA_WIDTH(8)) sif_b [NB] ();
  axis_if #(.TDATA_WIDTH(8)) mif_b ();

  for (genvar g = 0; g < NB; g++) begin : g_b
    assign sif_b[g].tvalid = vld_b[g];
    assign sif_b[g].tdata  = dat_b[g];
    assign rdy_b[g]        = sif_b[g].tready;
  end
  assign mif_b.tready = 1'b1;

  axis_rr_arbiter #(.NUM_REQ(NB), .MAX_BURST(1)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .axis_sif   (sif_b),
    .axis_mif   (mif_b),
    .mif_id     (id_b),
    .invalidate (1'b0)
  );

  initial begin
    int e;
    for (int i = 0; i < NB; i++) dat_b[i] = 8'(16 * (i + 1));
    for (int c = 0; c < 200 && rst; c++) @(negedge clk);
    @(posedge clk);
    #1;
    vld_b = '1;
    for (int k = 0; k < 9; k++) qb.push_back(k % NB);
    @(negedge clk);
    chk_eq("b_first_tready", 32'(rdy_b), 32'd1);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      e = qb.pop_front();
      chk_eq("b_tvalid", 32'(mif_b.tvalid), 32'd1);
      chk_eq("b_id", 32'(id_b), 32'(e));
      chk_eq("b_data", 32'(mif_b.tdata), 32'(16 * (e + 1)));
    end
    vld_b  = '0;
    b_done = 1'b1;
  end

  // ---------------- main sequence for instance A ----------------
  int exp_burst [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
  int ptr_saved;

  initial begin
    for (int i = 0; i < NA; i++) begin
      dat_a[i]   = '0;
      src_cnt[i] = 0;
    end
    step('0, 1'b1, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1);
    step('1, 1'b1, 1'b0, 1'b1);
    chk_eq("rst_tdata", 32'(mif_a.tdata), 32'd0);
    chk_eq("rst_id", 32'(id_a), 32'd0);
    vld_a = '0;
    step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);

    dat_a[2] = 16'h00A5;
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    chk_eq("a5_handshake", 32'(rdy_a), 32'h4);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk_eq("a5_tvalid", 32'(mif_a.tvalid), 32'd1);
    chk_eq("a5_tdata", 32'(mif_a.tdata), 32'h00A5);
    chk_eq("a5_id", 32'(id_a), 32'd2);
    step(4'b0000, 1'b1, 1'b0, 1'b0);

    // burst lock, then owner drop after two beats
    stream = 1'b1;
    log_ids.delete();
    for (int c = 0; c < 10; c++) step(4'b0011, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++)  step(4'b0010, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++)  step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk_eq("burst_len", 32'(log_ids.size()), 32'd14);
    for (int k = 0; k < 14 && k < log_ids.size(); k++) begin
      chk_eq($sformatf("burst_id%0d", k), 32'(log_ids[k]), 32'(exp_burst[k]));
    end

    // random backpressure with all four streaming
    for (int c = 0; c < 200; c++) step(4'b1111, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int c = 0; c < 4; c++)   step(4'b0000, 1'b1, 1'b0, 1'b0);
    chk_eq("bp_drained", 32'(sb.size()), 32'd0);

    // invalidate while stalled
    ptr_saved = m_ptr;
    step(4'b1111, 1'b0, 1'b0, 1'b0);
    chk_eq("pre_inv_grant", 32'(rdy_a), 32'(1 << ptr_saved));
    step(4'b1111, 1'b0, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b1, 1'b0);
    chk_eq("inv_no_handshake", 32'(rdy_a), 32'd0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk_eq("inv_flushed", 32'(mif_a.tvalid), 32'd0);
    step(4'b1111, 1'b1, 1'b0, 1'b0);
    chk_eq("inv_next_grant", 32'(rdy_a), 32'(1 << ptr_saved));
    for (int c = 0; c < 6; c++) step(4'b1111, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1, 1'b0, 1'b0);

    for (int c = 0; c < 100 && !b_done; c++) @(negedge clk);
    chk_eq("b_done", 32'(b_done), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
